// File: rtl/mux_scan_serializer_if.sv
// Handshake bundle for mux_scan_serializer: parallel word in, serial bits out.
// slave is the serializer side, master the producer/consumer side.
interface mux_scan_serializer_if;
    logic [7:0] I;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic       out;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport slave (
        input  I, in_valid, out_ready,
        output in_ready, sel, out, out_valid, out_last
    );

    modport master (
        output I, in_valid, out_ready,
        input  in_ready, sel, out, out_valid, out_last
    );
endinterface

// File: rtl/mux_scan_serializer.sv
// Byte-to-bit scan serializer: captures a word, muxes out one bit per beat.
// Define SCAN_PARITY_EN to append an even-parity beat after the 8 data bits.
module mux_scan_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    mux_scan_serializer_if.slave  bus
);
    localparam logic [2:0] SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] SEL_LAST  = MSB_FIRST ? 3'd0 : 3'd7;

`ifdef SCAN_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t     r_state;
    logic [7:0] r_data;
    logic [2:0] r_sel;

    logic       w_shift;
    logic       w_par;
    logic       w_at_last;
    logic       w_last;
    logic       w_bit;
    logic [2:0] w_sel_next;

    assign w_shift    = (r_state == SHIFT);
    assign w_at_last  = (r_sel == SEL_LAST);
    assign w_sel_next = MSB_FIRST ? r_sel - 3'd1 : r_sel + 3'd1;

`ifdef SCAN_PARITY_EN
    assign w_par  = (r_state == PAR);
    assign w_last = w_par;
`else
    assign w_par  = 1'b0;
    assign w_last = w_shift && w_at_last;
`endif

    always_comb begin
        w_bit = 1'b0;
        if (w_par)
            w_bit = ^r_data;
        else if (w_shift)
            w_bit = r_data[r_sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= 8'd0;
            r_sel   <= SEL_FIRST;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_data  <= bus.I;
                        r_sel   <= SEL_FIRST;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // sel parks on the last index; it never wraps
                    if (bus.out_ready) begin
`ifdef SCAN_PARITY_EN
                        if (w_at_last)
                            r_state <= PAR;
`else
                        if (w_at_last)
                            r_state <= IDLE;
`endif
                        else
                            r_sel <= w_sel_next;
                    end
                end
`ifdef SCAN_PARITY_EN
                PAR: begin
                    if (bus.out_ready)
                        r_state <= IDLE;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    // outputs are forced quiet while reset is asserted
    assign bus.in_ready  = !rst && (r_state == IDLE);
    assign bus.out_valid = !rst && (w_shift || w_par);
    assign bus.out_last  = !rst && w_last;
    assign bus.out       = !rst && w_bit;
    assign bus.sel       = r_sel;
endmodule

// File: tb/tb_mux_scan_serializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share one stimulus
// stream; a frame model queues expected beats, a monitor pops and compares.
module tb_mux_scan_serializer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_scan_serializer_if b0();
    mux_scan_serializer_if b1();

    mux_scan_serializer #(.MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    mux_scan_serializer #(.MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    assign b1.I         = b0.I;
    assign b1.in_valid  = b0.in_valid;
    assign b1.out_ready = b0.out_ready;

`ifdef SCAN_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    typedef struct packed {
        logic       b;
        logic       last;
        logic [2:0] sel;
    } beat_t;

    beat_t      q0[$];
    beat_t      q1[$];
    int         m_left;
    logic [2:0] m_idle0;
    logic [2:0] m_idle1;
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // frame model: a word becomes 8 (or 9) beats in scan order
    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            m_left  = 0;
            m_idle0 = 3'd0;
            m_idle1 = 3'd7;
        end else if (m_left > 0) begin
            if (b0.out_ready)
                m_left--;
        end else if (b0.in_valid) begin
            logic [7:0] w;
            logic       p;
            w = b0.I;
            p = 1'($countones(w) % 2);
            for (int k = 0; k < 8; k++) begin
                q0.push_back(beat_t'{b: w[k], last: (k == 7) && !HAS_PAR,
                                     sel: 3'(k)});
                q1.push_back(beat_t'{b: w[7-k], last: (k == 7) && !HAS_PAR,
                                     sel: 3'(7 - k)});
            end
            if (HAS_PAR) begin
                q0.push_back(beat_t'{b: p, last: 1'b1, sel: 3'd7});
                q1.push_back(beat_t'{b: p, last: 1'b1, sel: 3'd0});
            end
            m_left  = HAS_PAR ? 9 : 8;
            m_idle0 = 3'd7;
            m_idle1 = 3'd0;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("rst_outs",
                {b0.out_valid, b0.out_last, b0.out, b0.in_ready,
                 b1.out_valid, b1.out_last, b1.out, b1.in_ready}, 0);
        end else begin
            chk("in_ready0", b0.in_ready, m_left == 0);
            chk("in_ready1", b1.in_ready, m_left == 0);
            chk("out_valid0", b0.out_valid, m_left > 0);
            chk("out_valid1", b1.out_valid, m_left > 0);
            if (m_left == 0) begin
                chk("idle0", {b0.out, b0.out_last, b0.sel}, {2'b00, m_idle0});
                chk("idle1", {b1.out, b1.out_last, b1.sel}, {2'b00, m_idle1});
            end
            if (b0.out_valid) begin
                if (q0.size() == 0) begin
                    chk("beat0_unexpected", 1, 0);
                end else begin
                    chk("beat0", {b0.out, b0.out_last, b0.sel}, q0[0]);
                    if (b0.out_ready)
                        void'(q0.pop_front());
                end
            end
            if (b1.out_valid) begin
                if (q1.size() == 0) begin
                    chk("beat1_unexpected", 1, 0);
                end else begin
                    chk("beat1", {b1.out, b1.out_last, b1.sel}, q1[0]);
                    if (b1.out_ready)
                        void'(q1.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        b0.I        = w;
        b0.in_valid = 1'b1;
        tick();
        b0.in_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        b0.I         = 8'd0;
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        send(8'hAA);
        repeat (10) tick();
        send(8'hC1);
        repeat (10) tick();

        // stall three cycles with sel=2 on the LSB-first instance
        send(8'hA5);
        repeat (2) tick();
        b0.out_ready = 1'b0;
        repeat (3) tick();
        b0.out_ready = 1'b1;
        repeat (10) tick();

        // offered word during a frame must be ignored
        send(8'h0F);
        b0.I        = 8'hFF;
        b0.in_valid = 1'b1;
        repeat (4) tick();
        b0.in_valid = 1'b0;
        repeat (10) tick();

        // abort mid-frame, then a fresh word
        send(8'h5A);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send(8'h3C);
        repeat (10) tick();

        send(8'b1011_0000);
        repeat (11) tick();
        send(8'h00);
        repeat (11) tick();

        repeat (400) begin
            b0.I         = 8'($urandom);
            b0.in_valid  = 1'($urandom_range(0, 1));
            b0.out_ready = ($urandom_range(0, 3) != 0);
            rst          = ($urandom_range(0, 63) == 0);
            tick();
        end

        rst          = 1'b0;
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        repeat (12) tick();
        chk("drain", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_scan_serializer.md
MUX_SCAN_SERIALIZER -- requirements
Module: mux_scan_serializer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0: 0 selects scan order bit 0..7, 1 selects bit 7..0.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset sampled on the clk rising edge.
REQ-004 SHALL have port I, input, 8, the parallel data word offered for serialization.
REQ-005 SHALL have port in_valid, input, 1, meaning I holds a valid word.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-007 SHALL have port sel, output, 3, the current bit index applied to the captured word.
REQ-008 SHALL have port out, output, 1, the serial data bit.
REQ-009 SHALL have port out_valid, output, 1, meaning out holds a valid bit.
REQ-010 SHALL have port out_last, output, 1, meaning the current bit is the final bit of the frame.
REQ-011 SHALL have port out_ready, input, 1, meaning downstream accepts the bit this cycle.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and PAR; PAR exists only with SCAN_PARITY_EN.
REQ-013 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in all other states in_ready SHALL be 0.
REQ-014 On in_valid&&in_ready, SHALL capture I into an 8-bit data register, load sel with 0 (or 7 when MSB_FIRST=1), and go to SHIFT.
REQ-015 SHALL ignore in_valid whenever in_ready=0; the data register SHALL hold for the whole frame.
REQ-016 In SHIFT, out_valid SHALL be 1 and out SHALL equal data_reg[sel], combinational from registered state.
REQ-017 A bit SHALL transfer only on out_valid&&out_ready; on transfer, sel SHALL step +1 (or -1 when MSB_FIRST=1).
REQ-018 With out_ready=0, sel, out and out_last SHALL hold stable.
REQ-019 out_last SHALL be 1 in SHIFT when sel is 7 (or 0 when MSB_FIRST=1) and no parity stage follows; otherwise it SHALL be 0.
REQ-020 On transfer of the last data bit, SHALL go to PAR if parity is enabled, else to IDLE; sel SHALL NOT wrap into a ninth data beat.
REQ-021 Latency SHALL be: word accepted at edge N, first bit valid in cycle N+1; with out_ready tied high, one frame is 9 cycles (10 with parity), including one IDLE cycle.
REQ-022 In IDLE, out SHALL be 0 and sel SHALL hold its last value.

Reset
REQ-023 With rst high at a clk edge, SHALL go to IDLE, clear data_reg to 0 and set sel to 0 (or 7 when MSB_FIRST=1).
REQ-024 During rst high, SHALL output out_valid=0, out_last=0, out=0 and in_ready=0.
REQ-025 Reset during SHIFT or PAR SHALL abort the frame; partial frames SHALL NOT resume.

Configuration
REQ-026 Macro SCAN_PARITY_EN defined: after the 8th data bit, SHALL enter PAR with out_valid=1, out_last=1 and out equal to the XOR of the captured 8 bits (even parity); leave PAR to IDLE on out_ready.
REQ-027 Macro SCAN_PARITY_EN undefined: SHALL compile no PAR state, and frames SHALL be exactly 8 bits.

Verification
REQ-028 MSB_FIRST=0, I=8'b10101010, in_valid 1 cycle, out_ready=1 -> out 0,1,0,1,0,1,0,1 on consecutive cycles, sel 0..7, out_last only on the 8th, then in_ready=1.
REQ-029 MSB_FIRST=1, I=8'b11000001 -> out 1,1,0,0,0,0,0,1, sel 7..0, out_last at sel=0.
REQ-030 I=8'hA5, out_ready low for 3 cycles at sel=2 -> sel=2 and out=1 held for those 3 cycles, no bit lost, frame ends in 11 cycles.
REQ-031 in_valid with I=8'hFF during SHIFT of 8'h0F -> ignored, 8'h0F bits emitted intact.
REQ-032 rst pulsed at sel=4 -> next cycle IDLE, out_valid=0, in_ready=1, and a fresh 8'h3C serializes from sel 0.
REQ-033 SCAN_PARITY_EN, I=8'b10110000 -> 8 data bits, then a 9th beat with out=1 and out_last=1; with I=8'h00 the 9th beat is out=0.
